// File: rtl/sum_window_pkg.sv
// Shared helpers for the sum window accumulator: accumulator width and the
// round-half-up / saturate rule used to form the window mean.
package sum_window_pkg;

    localparam int CALC_W = 64;

    function automatic int f_acc_width(input int width_in, input int log2_frames);
        return width_in + log2_frames;
    endfunction

    // value arrives already sign/zero-extended to CALC_W, so the rounding add never wraps
    function automatic logic [CALC_W-1:0] f_round_shift(
        input logic [CALC_W-1:0] value,
        input int                width_in,
        input int                log2_frames,
        input bit                is_signed
    );
        logic [CALC_W-1:0] r;
        logic [CALC_W-1:0] hi;
        logic [CALC_W-1:0] lo;
        r  = value;
        hi = '0;
        lo = '0;
        if (log2_frames != 0) begin
            r = value + (CALC_W'(1) << (log2_frames - 1));
            if (is_signed)
                r = CALC_W'($signed(r) >>> log2_frames);
            else
                r = r >> log2_frames;
        end
        if (is_signed) begin
            hi = (CALC_W'(1) << (width_in - 1)) - CALC_W'(1);
            lo = ~hi;
            if ($signed(r) > $signed(hi))
                r = hi;
            else if ($signed(r) < $signed(lo))
                r = lo;
        end else begin
            hi = (CALC_W'(1) << width_in) - CALC_W'(1);
            if (r > hi)
                r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_window_out_reg.sv
// One-entry valid/ready holding register; a load in the same cycle as a
// consume wins, so valid stays high with the new data.
module sum_window_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sum_window_accumulator.sv
// Accumulates 2^LOG2_FRAMES samples and emits the window total and rounded mean.
// Optional SUM_WINDOW_PEAK_EN adds o_peak, the largest sample of each window.
module sum_window_accumulator
    import sum_window_pkg::*;
#(
    parameter int WIDTH_IN    = 19,
    parameter int IS_SIGNED   = 1,
    parameter int LOG2_FRAMES = 4,
    parameter int WIDTH_ACC   = f_acc_width(WIDTH_IN, LOG2_FRAMES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ena,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic [WIDTH_IN-1:0]  i_data,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH_ACC-1:0] o_sum,
    output logic [WIDTH_IN-1:0]  o_mean,
    output logic [LOG2_FRAMES:0] o_count
`ifdef SUM_WINDOW_PEAK_EN
    ,
    output logic [WIDTH_IN-1:0]  o_peak
`endif
);

    localparam int              CNT_W = LOG2_FRAMES + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_FRAMES) - 1);

    typedef struct packed {
        logic [WIDTH_ACC-1:0] sum;
        logic [WIDTH_IN-1:0]  mean;
`ifdef SUM_WINDOW_PEAK_EN
        logic [WIDTH_IN-1:0]  peak;
`endif
    } bundle_t;

    logic [WIDTH_ACC-1:0] acc_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WIDTH_ACC-1:0] ext_data;
    logic [WIDTH_ACC-1:0] nxt;
    logic [WIDTH_IN-1:0]  mean_next;
    logic                 last;
    logic                 accept;
    logic                 load;
    bundle_t              result_next;
    bundle_t              result_reg;

    // Only a finished window that cannot be parked in the output register stalls
    assign last    = (cnt_reg == LAST);
    assign o_ready = i_clr || !(last && o_valid && !i_ready);
    assign accept  = i_ena && i_valid && o_ready && !i_clr;
    assign load    = accept && last;
    assign nxt     = acc_reg + ext_data;

    generate
        if (IS_SIGNED != 0) begin : g_signed
            assign ext_data  = WIDTH_ACC'($signed(i_data));
            assign mean_next = WIDTH_IN'(f_round_shift(CALC_W'($signed(nxt)),
                                                       WIDTH_IN, LOG2_FRAMES, 1'b1));
        end else begin : g_unsigned
            assign ext_data  = WIDTH_ACC'(i_data);
            assign mean_next = WIDTH_IN'(f_round_shift(CALC_W'(nxt),
                                                       WIDTH_IN, LOG2_FRAMES, 1'b0));
        end
    endgenerate

`ifdef SUM_WINDOW_PEAK_EN
    logic [WIDTH_IN-1:0] peak_reg;
    logic [WIDTH_IN-1:0] peak_next;
    logic                greater;

    generate
        if (IS_SIGNED != 0) begin : g_peak_signed
            assign greater = $signed(i_data) > $signed(peak_reg);
        end else begin : g_peak_unsigned
            assign greater = i_data > peak_reg;
        end
    endgenerate

    // The first sample of a window (cnt == 0, also after a clear) reseeds the max
    assign peak_next = (cnt_reg == '0 || greater) ? i_data : peak_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            peak_reg <= '0;
        else if (accept)
            peak_reg <= peak_next;
    end
`endif

    always_comb begin
        result_next      = '0;
        result_next.sum  = nxt;
        result_next.mean = mean_next;
`ifdef SUM_WINDOW_PEAK_EN
        result_next.peak = peak_next;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (i_ena && i_clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            if (last) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= nxt;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    sum_window_out_reg #(
        .WIDTH($bits(bundle_t))
    ) u_out_reg (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (load),
        .load_data(result_next),
        .ready    (i_ready),
        .valid    (o_valid),
        .data     (result_reg)
    );

    assign o_sum   = result_reg.sum;
    assign o_mean  = result_reg.mean;
    assign o_count = cnt_reg;
`ifdef SUM_WINDOW_PEAK_EN
    assign o_peak  = result_reg.peak;
`endif

endmodule
